// File: rtl/bombe_pkg.sv
// Shared constants, FSM state encodings and mod-26 arithmetic helpers for the
// crib-driven bombe key search.
//   ALPHA      : alphabet size
//   ORD_A      : ASCII code of 'A'
//   ERROR_VAL  : all-ones marker presented on setting_out when the key space is exhausted
//   IDLE/SEARCH/FOUND/EXHAUSTED : 2-bit FSM state encodings (visible on state_out)
// All mod-26 helpers work on 7-bit values so sums never overflow before reduction.
package bombe_pkg;

    localparam int unsigned ALPHA     = 26;
    localparam int unsigned ORD_A     = 65;
    localparam int unsigned MAX_SET_W = 15;

    localparam logic [MAX_SET_W-1:0] ERROR_VAL = '1;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] SEARCH    = 2'd1;
    localparam logic [1:0] FOUND     = 2'd2;
    localparam logic [1:0] EXHAUSTED = 2'd3;

    // Single compare-and-subtract; valid for inputs in 0..2*ALPHA-1.
    function automatic logic [6:0] mod26_wrap(input logic [6:0] s);
        return (s >= 7'(ALPHA)) ? s - 7'(ALPHA) : s;
    endfunction

    // a, b already reduced (0..25).
    function automatic logic [6:0] mod26_add(input logic [6:0] a, input logic [6:0] b);
        return mod26_wrap(a + b);
    endfunction

    // a, b already reduced (0..25); bias by ALPHA keeps the difference non-negative.
    function automatic logic [6:0] mod26_sub(input logic [6:0] a, input logic [6:0] b);
        return mod26_wrap(a + 7'(ALPHA) - b);
    endfunction

endpackage

// File: rtl/bombe_search_if.sv
// Host-side bundle of the bombe search engine.
//   char_in/char_valid/char_is_plain : crib character load strobe
//   go / next                        : start search / resume after a hit
//   busy/found/exhausted/bad_char    : status flags
//   setting_out                      : 5 bits per rotor, rotor k at [5k+4:5k]
//   state_out                        : FSM state encoding
// master = host driving commands, slave = search engine.
interface bombe_search_if #(
    parameter int NUM_ROTORS = 1
);
    logic [7:0]              char_in;
    logic                    char_valid;
    logic                    char_is_plain;
    logic                    go;
    logic                    next;
    logic                    busy;
    logic                    found;
    logic                    exhausted;
    logic                    bad_char;
    logic [5*NUM_ROTORS-1:0] setting_out;
    logic [1:0]              state_out;

    modport master (
        output char_in, char_valid, char_is_plain, go, next,
        input  busy, found, exhausted, bad_char, setting_out, state_out
    );

    modport slave (
        input  char_in, char_valid, char_is_plain, go, next,
        output busy, found, exhausted, bad_char, setting_out, state_out
    );

endinterface

// File: rtl/mod26_odometer.sv
// NUM_ROTORS-digit base-26 counter (rotor 0 fastest).
//   clk, reset : clock, synchronous active-high reset (clears to all zeros)
//   inc        : step the odometer by one
//   load       : load load_val (has priority over inc)
//   load_val   : value to load, 5 bits per rotor
//   value      : current rotor positions, rotor k at [5k+4:5k]
//   next_val   : combinational value after one step
//   last       : all rotors at 25
module mod26_odometer
    import bombe_pkg::*;
#(
    parameter int NUM_ROTORS = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    inc,
    input  logic                    load,
    input  logic [5*NUM_ROTORS-1:0] load_val,
    output logic [5*NUM_ROTORS-1:0] value,
    output logic [5*NUM_ROTORS-1:0] next_val,
    output logic                    last
);

    logic [5*NUM_ROTORS-1:0] val_q;
    logic                    carry;

    // Ripple carry: a rotor steps only while every faster rotor is wrapping 25 -> 0.
    always_comb begin
        next_val = val_q;
        carry    = 1'b1;
        last     = 1'b1;
        for (int k = 0; k < NUM_ROTORS; k++) begin
            last = last & (val_q[5*k +: 5] == 5'(ALPHA - 1));
            if (carry) begin
                if (val_q[5*k +: 5] == 5'(ALPHA - 1)) begin
                    next_val[5*k +: 5] = 5'd0;
                end else begin
                    next_val[5*k +: 5] = val_q[5*k +: 5] + 5'd1;
                    carry              = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            val_q <= '0;
        end else if (load) begin
            val_q <= load_val;
        end else if (inc) begin
            val_q <= next_val;
        end
    end

    assign value = val_q;

endmodule

// File: rtl/bombe_search.sv
// Crib-driven exhaustive key search over a NUM_ROTORS odometer (26^NUM_ROTORS settings).
//   clk, reset : clock, synchronous active-high reset
//   bus        : bombe_search_if slave (crib loading, go/next, status, setting_out, state_out)
// A candidate counter holds the initial rotor setting under test; a stepping copy advances
// once per crib position. One crib position is compared per clock and a candidate is
// dropped on its first mismatch.
module bombe_search
    import bombe_pkg::*;
#(
    parameter int CRIB_LEN   = 3,
    parameter int NUM_ROTORS = 1
) (
    input  logic           clk,
    input  logic           reset,
    bombe_search_if.slave  bus
);

    localparam int PTR_W = $clog2(CRIB_LEN + 1);
    localparam int POS_W = $clog2(CRIB_LEN);
    localparam int DEPTH = 1 << POS_W;
    localparam int SET_W = 5 * NUM_ROTORS;

    logic [1:0]       state_q, state_d;
    logic [PTR_W-1:0] plain_ptr_q, cipher_ptr_q;
    logic [POS_W-1:0] pos_q;
    logic [SET_W-1:0] setting_q;
    logic             bad_char_q;
    logic [4:0]       plain_mem  [DEPTH];
    logic [4:0]       cipher_mem [DEPTH];

    // Odometer wiring
    logic [SET_W-1:0] cand_val, cand_next, step_val, step_next, step_load_val;
    logic             cand_last, step_last, step_unused;

    // Control strobes from the output process
    logic start, advance, pos_inc, set_hit, set_exh;

    // ---------------------------------------------------------------- loading
    logic [7:0] char_off;
    logic       is_upper, plain_full, cipher_full, in_idle;
    logic       wr_plain, wr_cipher, bad_wr;

    assign in_idle     = (state_q == IDLE);
    assign char_off    = bus.char_in - 8'(ORD_A);
    assign is_upper    = (char_off < 8'(ALPHA));
    assign plain_full  = (plain_ptr_q == PTR_W'(CRIB_LEN));
    assign cipher_full = (cipher_ptr_q == PTR_W'(CRIB_LEN));
    assign wr_plain    = in_idle && bus.char_valid && is_upper && bus.char_is_plain && !plain_full;
    assign wr_cipher   = in_idle && bus.char_valid && is_upper && !bus.char_is_plain
                         && !cipher_full;
    assign bad_wr      = in_idle && bus.char_valid && !is_upper;

    // ------------------------------------------------------------- comparison
    logic [6:0] shift, diff;
    logic       match, pos_last;

    always_comb begin
        shift = 7'd0;
        for (int k = 0; k < NUM_ROTORS; k++) begin
            shift = mod26_add(shift, {2'b00, step_val[5*k +: 5]});
        end
    end

    assign diff     = mod26_sub(mod26_sub({2'b00, cipher_mem[pos_q]}, {2'b00, plain_mem[pos_q]}),
                                shift);
    assign match    = (diff == 7'd0);
    assign pos_last = (pos_q == POS_W'(CRIB_LEN - 1));

    // ------------------------------------------------------------- odometers
    mod26_odometer #(
        .NUM_ROTORS (NUM_ROTORS)
    ) u_cand (
        .clk      (clk),
        .reset    (reset),
        .inc      (advance),
        .load     (start),
        .load_val ('0),
        .value    (cand_val),
        .next_val (cand_next),
        .last     (cand_last)
    );

    // The stepping copy restarts from the next candidate at the same edge the candidate
    // counter advances, so no cycle is lost between candidates.
    assign step_load_val = start ? '0 : cand_next;

    mod26_odometer #(
        .NUM_ROTORS (NUM_ROTORS)
    ) u_step (
        .clk      (clk),
        .reset    (reset),
        .inc      (pos_inc),
        .load     (start || advance),
        .load_val (step_load_val),
        .value    (step_val),
        .next_val (step_next),
        .last     (step_last)
    );

    assign step_unused = ^{step_next, step_last};

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.go && plain_full && cipher_full) state_d = SEARCH;
            end
            SEARCH: begin
                if (!match) begin
                    if (cand_last) state_d = EXHAUSTED;
                end else if (pos_last) begin
                    state_d = FOUND;
                end
            end
            FOUND: begin
                // go wins over next
                if (bus.go) begin
                    state_d = IDLE;
                end else if (bus.next) begin
                    state_d = cand_last ? EXHAUSTED : SEARCH;
                end
            end
            EXHAUSTED: begin
                if (bus.go) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start         = 1'b0;
        advance       = 1'b0;
        pos_inc       = 1'b0;
        set_hit       = 1'b0;
        set_exh       = 1'b0;
        bus.busy      = (state_q == SEARCH);
        bus.found     = (state_q == FOUND);
        bus.exhausted = (state_q == EXHAUSTED);
        unique case (state_q)
            IDLE: begin
                start = bus.go && plain_full && cipher_full;
            end
            SEARCH: begin
                if (!match) begin
                    if (cand_last) set_exh = 1'b1;
                    else           advance = 1'b1;
                end else if (pos_last) begin
                    set_hit = 1'b1;
                end else begin
                    pos_inc = 1'b1;
                end
            end
            FOUND: begin
                if (!bus.go && bus.next) begin
                    if (cand_last) set_exh = 1'b1;
                    else           advance = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            plain_ptr_q  <= '0;
            cipher_ptr_q <= '0;
            pos_q        <= '0;
            setting_q    <= '0;
            bad_char_q   <= 1'b0;
        end else begin
            if (wr_plain)  plain_ptr_q  <= plain_ptr_q + PTR_W'(1);
            if (wr_cipher) cipher_ptr_q <= cipher_ptr_q + PTR_W'(1);
            if (bad_wr)    bad_char_q   <= 1'b1;

            if (start || advance) begin
                pos_q <= '0;
            end else if (pos_inc) begin
                pos_q <= pos_q + POS_W'(1);
            end

            if (start) begin
                setting_q <= '0;
            end else if (set_hit) begin
                setting_q <= cand_val;
            end else if (set_exh) begin
                setting_q <= ERROR_VAL[SET_W-1:0];
            end
        end
    end

    // Crib storage needs no reset: the pointers gate every use of it.
    always_ff @(posedge clk) begin
        if (wr_plain)  plain_mem[plain_ptr_q[POS_W-1:0]]   <= char_off[4:0];
        if (wr_cipher) cipher_mem[cipher_ptr_q[POS_W-1:0]] <= char_off[4:0];
    end

    assign bus.bad_char    = bad_char_q;
    assign bus.setting_out = setting_q;
    assign bus.state_out   = state_q;

endmodule

// File: tb/tb_bombe_search.sv
module tb_bombe_search;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] char_in = 8'd0;
    logic       char_valid = 1'b0;
    logic       char_is_plain = 1'b0;
    logic       go = 1'b0;
    logic       next = 1'b0;
    int         sel = 0;

    int tests_run    = 0;
    int tests_failed = 0;

    int m_plain [16];
    int m_ciph  [16];

    always #5 clk = ~clk;

    // dut_a: CRIB_LEN 3, 1 rotor; dut_b: CRIB_LEN 3, 2 rotors; dut_c: CRIB_LEN 2, 1 rotor
    bombe_search_if #(.NUM_ROTORS(1)) if_a ();
    bombe_search_if #(.NUM_ROTORS(2)) if_b ();
    bombe_search_if #(.NUM_ROTORS(1)) if_c ();

    assign if_a.char_in = char_in;
    assign if_b.char_in = char_in;
    assign if_c.char_in = char_in;
    assign if_a.char_is_plain = char_is_plain;
    assign if_b.char_is_plain = char_is_plain;
    assign if_c.char_is_plain = char_is_plain;
    assign if_a.char_valid = char_valid && (sel == 0);
    assign if_b.char_valid = char_valid && (sel == 1);
    assign if_c.char_valid = char_valid && (sel == 2);
    assign if_a.go = go && (sel == 0);
    assign if_b.go = go && (sel == 1);
    assign if_c.go = go && (sel == 2);
    assign if_a.next = next && (sel == 0);
    assign if_b.next = next && (sel == 1);
    assign if_c.next = next && (sel == 2);

    bombe_search #(.CRIB_LEN(3), .NUM_ROTORS(1)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
    bombe_search #(.CRIB_LEN(3), .NUM_ROTORS(2)) dut_b (.clk(clk), .reset(reset), .bus(if_b));
    bombe_search #(.CRIB_LEN(2), .NUM_ROTORS(1)) dut_c (.clk(clk), .reset(reset), .bus(if_c));

    logic       busy_m, found_m, exh_m, bad_m;
    logic [1:0] state_m;
    logic [9:0] setting_m;

    always_comb begin
        case (sel)
            0: begin
                busy_m = if_a.busy; found_m = if_a.found; exh_m = if_a.exhausted;
                bad_m = if_a.bad_char; state_m = if_a.state_out;
                setting_m = {5'd0, if_a.setting_out};
            end
            1: begin
                busy_m = if_b.busy; found_m = if_b.found; exh_m = if_b.exhausted;
                bad_m = if_b.bad_char; state_m = if_b.state_out;
                setting_m = if_b.setting_out;
            end
            default: begin
                busy_m = if_c.busy; found_m = if_c.found; exh_m = if_c.exhausted;
                bad_m = if_c.bad_char; state_m = if_c.state_out;
                setting_m = {5'd0, if_c.setting_out};
            end
        endcase
    end

    // ------------------------------------------------------------ reference model
    function automatic int nrot_of(input int s);
        return (s == 1) ? 2 : 1;
    endfunction

    function automatic int clen_of(input int s);
        return (s == 2) ? 2 : 3;
    endfunction

    // The stepping copy at position i is just the integer candidate + i in base 26.
    function automatic int shift_of(input int nr, input int v);
        int s;
        s = 0;
        for (int k = 0; k < nr; k++) begin
            s = s + v % 26;
            v = v / 26;
        end
        return s % 26;
    endfunction

    function automatic void model(input int s, input int start, output int hit, output int cycles);
        int  nr, cl, total, d;
        bit  ok;
        nr = nrot_of(s);
        cl = clen_of(s);
        total = 26 ** nr;
        hit = -1;
        cycles = 0;
        for (int c = start; c < total; c++) begin
            ok = 1'b1;
            for (int i = 0; i < cl; i++) begin
                cycles++;
                d = ((m_ciph[i] - m_plain[i] - shift_of(nr, (c + i) % total)) % 26 + 26) % 26;
                if (d != 0) begin
                    ok = 1'b0;
                    break;
                end
            end
            if (ok) begin
                hit = c;
                return;
            end
        end
    endfunction

    function automatic logic [9:0] pack(input int nr, input int c);
        logic [9:0] r;
        r = '0;
        for (int k = 0; k < nr; k++) begin
            r[5*k +: 5] = 5'(c % 26);
            c = c / 26;
        end
        return r;
    endfunction

    function automatic logic [9:0] ones(input int nr);
        logic [9:0] r;
        r = '0;
        for (int k = 0; k < 5 * nr; k++) r[k] = 1'b1;
        return r;
    endfunction

    function automatic void set_model(input string p, input string c);
        for (int i = 0; i < p.len(); i++) m_plain[i] = int'(p[i]) - 65;
        for (int i = 0; i < c.len(); i++) m_ciph[i] = int'(c[i]) - 65;
    endfunction

    // ------------------------------------------------------------------ drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        go = 1'b0; next = 1'b0; char_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic load_char(input bit is_plain, input byte c);
        char_in = c;
        char_is_plain = is_plain;
        char_valid = 1'b1;
        tick();
        char_valid = 1'b0;
    endtask

    task automatic load_str(input bit is_plain, input string s);
        for (int i = 0; i < s.len(); i++) load_char(is_plain, s[i]);
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic pulse_next();
        next = 1'b1;
        tick();
        next = 1'b0;
    endtask

    // Counts clocks from the go/next edge until found or exhausted, checks against model.
    task automatic run_check(input string name, input int start, output int hit, output int n);
        int cyc, bound, nr;
        nr = nrot_of(sel);
        model(sel, start, hit, cyc);
        bound = (26 ** nr) * clen_of(sel) + 20;
        n = 0;
        while (!found_m && !exh_m && n < bound) begin
            tick();
            n++;
        end
        tests_run++;
        if (n !== cyc) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d clocks, expected %0d", name, n, cyc);
        end
        tests_run++;
        if ({found_m, exh_m} !== ((hit >= 0) ? 2'b10 : 2'b01)) begin
            tests_failed++;
            $display("FAIL %s outcome: got found=%0b exh=%0b, expected hit=%0d",
                     name, found_m, exh_m, hit);
        end
        tests_run++;
        if (setting_m !== ((hit >= 0) ? pack(nr, hit) : ones(nr))) begin
            tests_failed++;
            $display("FAIL %s setting: got %h, expected %h", name, setting_m,
                     (hit >= 0) ? pack(nr, hit) : ones(nr));
        end
    endtask

    // -------------------------------------------------------------------- tests
    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            sel = s;
            do_reset();
            tests_run++;
            if ({state_m, busy_m, found_m, exh_m, bad_m, setting_m} !== 16'd0) begin
                tests_failed++;
                $display("FAIL reset[%0d]: got state=%0d b/f/e/bad=%b%b%b%b set=%h, expected 0",
                         s, state_m, busy_m, found_m, exh_m, bad_m, setting_m);
            end
        end
    endtask

    task automatic test_known_hit();
        int hit, n;
        sel = 0;
        do_reset();
        load_str(1'b1, "ABC");
        load_str(1'b0, "FHJ");
        set_model("ABC", "FHJ");
        pulse_go();
        tests_run++;
        if (state_m !== 2'd1 || busy_m !== 1'b1) begin
            tests_failed++;
            $display("FAIL go_to_search: got state=%0d busy=%b, expected 1/1", state_m, busy_m);
        end
        run_check("known_hit", 0, hit, n);
        tests_run++;
        if (n !== 8 || setting_m !== 10'd5 || exh_m !== 1'b0) begin
            tests_failed++;
            $display("FAIL known_hit_fixed: got %0d clocks set=%0d exh=%b, expected 8/5/0",
                     n, setting_m, exh_m);
        end
    endtask

    task automatic test_exhausted();
        int hit, n;
        sel = 0;
        do_reset();
        load_str(1'b1, "AAA");
        load_str(1'b0, "ABA");
        set_model("AAA", "ABA");
        pulse_go();
        run_check("exhaust_1rotor", 0, hit, n);
        tests_run++;
        if (setting_m !== 10'h01F || found_m !== 1'b0) begin
            tests_failed++;
            $display("FAIL exhaust_fixed: got set=%h found=%b, expected 01f/0", setting_m, found_m);
        end
        pulse_go();
        tests_run++;
        if (state_m !== 2'd0) begin
            tests_failed++;
            $display("FAIL exhaust_go_idle: got state=%0d, expected 0", state_m);
        end
    endtask

    task automatic test_two_rotor();
        int hit, n;
        sel = 1;
        do_reset();
        load_str(1'b1, "AAA");
        load_str(1'b0, "BCE");
        set_model("AAA", "BCE");
        pulse_go();
        run_check("two_rotor_hit", 0, hit, n);
        tests_run++;
        if (setting_m !== {5'd3, 5'd24}) begin
            tests_failed++;
            $display("FAIL two_rotor_fixed: got %h, expected %h", setting_m, {5'd3, 5'd24});
        end
        pulse_next();
        run_check("two_rotor_next", hit + 1, hit, n);
    endtask

    task automatic test_bad_char();
        int hit, n;
        sel = 0;
        do_reset();
        load_str(1'b1, "a7ABCZ");
        tests_run++;
        if (bad_m !== 1'b1) begin
            tests_failed++;
            $display("FAIL bad_char: got %b, expected 1", bad_m);
        end
        pulse_go();
        tests_run++;
        if (state_m !== 2'd0) begin
            tests_failed++;
            $display("FAIL go_cipher_empty: got state=%0d, expected 0", state_m);
        end
        load_str(1'b0, "FH");
        // Last cipher write with go: go sees the pre-write pointer and is ignored.
        char_in = "J"; char_is_plain = 1'b0; char_valid = 1'b1; go = 1'b1;
        tick();
        char_valid = 1'b0; go = 1'b0;
        tests_run++;
        if (state_m !== 2'd0) begin
            tests_failed++;
            $display("FAIL go_with_write: got state=%0d, expected 0", state_m);
        end
        set_model("ABC", "FHJ");
        pulse_go();
        run_check("bad_char_crib", 0, hit, n);
        tests_run++;
        if (bad_m !== 1'b1) begin
            tests_failed++;
            $display("FAIL bad_char_sticky: got %b, expected 1", bad_m);
        end
    endtask

    task automatic test_reset_mid_search();
        sel = 0;
        do_reset();
        load_str(1'b1, "AAA");
        load_str(1'b0, "ABA");
        pulse_go();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests_run++;
        if ({state_m, busy_m, setting_m} !== 13'd0) begin
            tests_failed++;
            $display("FAIL mid_reset: got state=%0d busy=%b set=%h, expected 0",
                     state_m, busy_m, setting_m);
        end
        pulse_go();
        tests_run++;
        if (state_m !== 2'd0) begin
            tests_failed++;
            $display("FAIL go_after_reset: got state=%0d, expected 0", state_m);
        end
        load_str(1'b1, "AAA");
        load_str(1'b0, "ABA");
        pulse_go();
        tests_run++;
        if (busy_m !== 1'b1) begin
            tests_failed++;
            $display("FAIL reload_go: got busy=%b, expected 1", busy_m);
        end
    endtask

    task automatic test_crib2();
        int hit, n;
        sel = 2;
        do_reset();
        load_str(1'b1, "AB");
        load_str(1'b0, "BC");
        set_model("AB", "BC");
        pulse_go();
        run_check("crib2_const_diff", 0, hit, n);

        do_reset();
        load_str(1'b1, "AB");
        load_str(1'b0, "BD");
        set_model("AB", "BD");
        pulse_go();
        run_check("crib2_hit", 0, hit, n);
        pulse_next();
        run_check("crib2_next", hit + 1, hit, n);
        pulse_go();
        pulse_go();
        run_check("crib2_rerun", 0, hit, n);
        go = 1'b1; next = 1'b1;
        tick();
        go = 1'b0; next = 1'b0;
        tests_run++;
        if (state_m !== 2'd0 || found_m !== 1'b0) begin
            tests_failed++;
            $display("FAIL go_beats_next: got state=%0d found=%b, expected 0/0", state_m, found_m);
        end
    endtask

    task automatic test_random();
        int nr, cl, total, h, hit, n, start, guard;
        for (int s = 0; s < 3; s++) begin
            for (int t = 0; t < 3; t++) begin
                sel = s;
                nr = nrot_of(s);
                cl = clen_of(s);
                total = 26 ** nr;
                do_reset();
                h = int'($urandom_range(0, total - 1));
                for (int i = 0; i < cl; i++) begin
                    m_plain[i] = int'($urandom_range(0, 25));
                    m_ciph[i] = (m_plain[i] + shift_of(nr, (h + i) % total)) % 26;
                end
                for (int i = 0; i < cl; i++) load_char(1'b1, 8'(65 + m_plain[i]));
                for (int i = 0; i < cl; i++) load_char(1'b0, 8'(65 + m_ciph[i]));
                pulse_go();
                start = 0;
                guard = 0;
                do begin
                    run_check("random", start, hit, n);
                    if (hit >= 0) begin
                        pulse_next();
                        start = hit + 1;
                    end
                    guard++;
                end while (hit >= 0 && guard < 40);
            end
        end
    endtask

    initial begin
        test_reset();
        test_known_hit();
        test_exhausted();
        test_two_rotor();
        test_bad_char();
        test_reset_mid_search();
        test_crib2();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
